// File: rtl/valid4_loader.sv
// Collects up to four samples into a group and holds it for a downstream register,
// which loads the group on the next periodic Tick.
module valid4_loader #(
  parameter int unsigned NrOfBits   = 8,
  parameter int unsigned TickDivide = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NrOfBits-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  Tick,
  output logic                  ClockEnable,
  output logic [4*NrOfBits-1:0] D_word,
  output logic [3:0]            D_valid
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  localparam logic [7:0] TickMax = 8'(TickDivide - 1);

  logic [7:0]            tick_cnt_q, tick_cnt_d;
  state_e                state_q, state_d;
  logic [2:0]            fill_q, fill_d;
  logic [4*NrOfBits-1:0] word_q, word_d;
  logic [3:0]            valid_q, valid_d;
  logic                  tick_raw;
  logic                  accept;

  assign tick_raw   = (tick_cnt_q == TickMax);
  assign tick_cnt_d = tick_raw ? 8'd0 : tick_cnt_q + 8'd1;

  // Handshake and tick outputs are all forced low while Reset is held.
  always_comb begin
    in_ready    = 1'b0;
    ClockEnable = 1'b0;
    Tick        = 1'b0;
    if (!Reset) begin
      in_ready    = (state_q == StFill);
      ClockEnable = (state_q == StHold);
      Tick        = tick_raw;
    end
  end

  assign accept  = in_valid & in_ready;
  assign D_word  = word_q;
  assign D_valid = valid_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    word_d  = word_q;
    valid_d = valid_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            if (fill_q == 3'(k)) begin
              word_d[k*NrOfBits +: NrOfBits] = in_data;
              valid_d[k]                     = 1'b1;
            end
          end
          fill_d = fill_q + 3'd1;
        end
        // A flush coinciding with an accept still stores the sample first.
        if ((accept && fill_q == 3'd3) || (flush && (accept || fill_q != 3'd0))) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (Tick) begin
          word_d  = '0;
          valid_d = '0;
          fill_d  = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tick_cnt_q <= '0;
      state_q    <= StFill;
      fill_q     <= '0;
      word_q     <= '0;
      valid_q    <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      fill_q     <= fill_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_valid4_loader.sv
// Self-checking bench for valid4_loader: TickDivide=4 instance for group/flush/reset
// scenarios, TickDivide=1 instance for continuous streaming.
module tb_valid4_loader;

  localparam int unsigned W  = 8;
  localparam int unsigned TD = 4;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic           Reset;
  logic [W-1:0]   in_data;
  logic           in_valid, in_ready, flush, Tick, ClockEnable;
  logic [4*W-1:0] D_word;
  logic [3:0]     D_valid;

  logic [W-1:0]   in_data1;
  logic           in_valid1, in_ready1, flush1, Tick1, ce1;
  logic [4*W-1:0] dw1;
  logic [3:0]     dv1;

  valid4_loader #(.NrOfBits(W), .TickDivide(TD)) dut (
    .Clock(Clock), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .Tick(Tick), .ClockEnable(ClockEnable),
    .D_word(D_word), .D_valid(D_valid)
  );

  valid4_loader #(.NrOfBits(W), .TickDivide(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .flush(flush1), .Tick(Tick1), .ClockEnable(ce1),
    .D_word(dw1), .D_valid(dv1)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  valid;
  } grp_t;

  grp_t        exp_q[$];
  logic [7:0]  samp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_cnt;

  // Reference tick phase for the TickDivide=4 instance.
  always @(posedge Clock) begin
    if (Reset) m_cnt <= 0;
    else       m_cnt <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
  end

  // Waits (bounded) for the hand-off cycle while in HOLD and captures what was presented.
  task automatic await_handoff(output bit seen, output int hold, output bit unstable,
                               output logic [31:0] w, output logic [3:0] v);
    logic [31:0] w0;
    logic [3:0]  v0;
    seen = 0; hold = 0; unstable = 0; w = '0; v = '0;
    w0 = D_word; v0 = D_valid;
    for (int i = 0; i < 2 * TD + 2 && !seen; i++) begin
      hold++;
      if (D_word !== w0 || D_valid !== v0 || ClockEnable !== 1'b1) unstable = 1;
      if (Tick === 1'b1) begin
        seen = 1; w = D_word; v = D_valid;
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    checks++; if (in_ready !== 1'b0 || ClockEnable !== 1'b0 || Tick !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b ce=%b tick=%b expected 0 0 0",
                         in_ready, ClockEnable, Tick);
    end
    checks++; if (D_word !== 32'h0 || D_valid !== 4'h0) begin
      errors++; $display("FAIL reset_data: got %h/%b expected 00000000/0000", D_word, D_valid);
    end
    Reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    for (int i = 1; i <= TD; i++) begin
      checks++; if (Tick !== (i == TD)) begin
        errors++; $display("FAIL reset_first_tick: cycle %0d got %b expected %b", i, Tick, i == TD);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_full_group;
    bit seen, unst; int hold; logic [31:0] w; logic [3:0] v; grp_t e;
    exp_q.push_back('{word: 32'h44332211, valid: 4'b1111});
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(17 * (i + 1));
      checks++; if (in_ready !== 1'b1 || ClockEnable !== 1'b0) begin
        errors++; $display("FAIL full_fill: slot %0d got rdy=%b ce=%b expected 1 0",
                           i, in_ready, ClockEnable);
      end
      @(negedge Clock);
    end
    in_valid = 1'b0;
    checks++; if (ClockEnable !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_hold: got ce=%b rdy=%b expected 1 0", ClockEnable, in_ready);
    end
    await_handoff(seen, hold, unst, w, v);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL full_handoff: got none expected one"); end
    checks++; if (w !== e.word) begin
      errors++; $display("FAIL full_word: got %h expected %h", w, e.word);
    end
    checks++; if (v !== e.valid) begin
      errors++; $display("FAIL full_valid: got %b expected %b", v, e.valid);
    end
    checks++; if (unst) begin errors++; $display("FAIL full_stable: got unstable expected stable"); end
    checks++; if (hold < 1 || hold > TD) begin
      errors++; $display("FAIL full_latency: got %0d expected 1..%0d", hold, TD);
    end
    checks++; if (D_valid !== 4'h0 || in_ready !== 1'b1 || D_word !== 32'h0) begin
      errors++; $display("FAIL full_cleared: got %b/%b/%h expected 0000/1/00000000",
                         D_valid, in_ready, D_word);
    end
  endtask

  task automatic test_flush_partial;
    bit seen, unst; int hold; logic [31:0] w; logic [3:0] v; grp_t e;
    exp_q.push_back('{word: 32'h000000A5, valid: 4'b0001});
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge Clock);
    in_valid = 1'b0; flush = 1'b1;
    checks++; if (ClockEnable !== 1'b0) begin
      errors++; $display("FAIL flush_pre: got ce=%b expected 0", ClockEnable);
    end
    @(negedge Clock);
    flush = 1'b0;
    await_handoff(seen, hold, unst, w, v);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL flush_handoff: got none expected one"); end
    checks++; if (w !== e.word || v !== e.valid) begin
      errors++; $display("FAIL flush_group: got %h/%b expected %h/%b", w, v, e.word, e.valid);
    end
    checks++; if (unst) begin errors++; $display("FAIL flush_stable: got unstable expected stable"); end
    checks++; if (D_valid !== 4'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_cleared: got %b/%b expected 0000/1", D_valid, in_ready);
    end
  endtask

  task automatic test_flush_empty;
    flush = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (ClockEnable !== 1'b0 || D_valid !== 4'h0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL flush_empty: cycle %0d got ce=%b v=%b rdy=%b expected 0 0000 1",
                           i, ClockEnable, D_valid, in_ready);
      end
      checks++; if (Tick !== (m_cnt == TD - 1)) begin
        errors++; $display("FAIL tick_period: cycle %0d got %b expected %b", i, Tick, m_cnt == TD - 1);
      end
      @(negedge Clock);
    end
    flush = 1'b0;
  endtask

  task automatic test_flush_concurrent;
    bit seen, unst; int hold; logic [31:0] w; logic [3:0] v; grp_t e;
    exp_q.push_back('{word: 32'h00CCBBAA, valid: 4'b0111});
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hAA + 8'(17 * i));
      flush   = (i == 2);
      @(negedge Clock);
    end
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (ClockEnable !== 1'b1) begin
      errors++; $display("FAIL concurrent_hold: got ce=%b expected 1", ClockEnable);
    end
    await_handoff(seen, hold, unst, w, v);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL concurrent_handoff: got none expected one"); end
    checks++; if (w !== e.word || v !== e.valid) begin
      errors++; $display("FAIL concurrent_group: got %h/%b expected %h/%b", w, v, e.word, e.valid);
    end
  endtask

  task automatic test_reset_in_hold;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      @(negedge Clock);
    end
    in_valid = 1'b0;
    checks++; if (ClockEnable !== 1'b1) begin
      errors++; $display("FAIL rst_hold_enter: got ce=%b expected 1", ClockEnable);
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++; if (D_valid !== 4'h0 || ClockEnable !== 1'b0 || Tick !== 1'b0) begin
      errors++; $display("FAIL rst_hold_discard: got v=%b ce=%b tick=%b expected 0000 0 0",
                         D_valid, ClockEnable, Tick);
    end
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || D_word !== 32'h0) begin
      errors++; $display("FAIL rst_hold_release: got rdy=%b w=%h expected 1 00000000", in_ready, D_word);
    end
    for (int i = 1; i <= TD; i++) begin
      checks++; if (Tick !== (i == TD)) begin
        errors++; $display("FAIL rst_hold_tick: cycle %0d got %b expected %b", i, Tick, i == TD);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_back_to_back;
    int          last_ho = -1;
    int          groups = 0;
    bit          accepted;
    logic [31:0] ew;
    in_data1  = 8'h01;
    in_valid1 = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (ce1 === 1'b1 && Tick1 === 1'b1) begin
        ew = '0;
        checks++; if (samp_q.size() < 4) begin
          errors++; $display("FAIL b2b_underflow: got %0d samples expected 4", samp_q.size());
        end else begin
          for (int k = 0; k < 4; k++) ew[k*8 +: 8] = samp_q.pop_front();
          checks++; if (dw1 !== ew || dv1 !== 4'b1111) begin
            errors++; $display("FAIL b2b_group: got %h/%b expected %h/1111", dw1, dv1, ew);
          end
        end
        if (last_ho >= 0) begin
          checks++; if (c - last_ho != 5) begin
            errors++; $display("FAIL b2b_period: got %0d expected 5", c - last_ho);
          end
        end
        last_ho = c;
        groups++;
      end
      accepted = (in_ready1 === 1'b1);
      if (accepted) samp_q.push_back(in_data1);
      @(negedge Clock);
      if (accepted) in_data1 = in_data1 + 8'd1;
    end
    in_valid1 = 1'b0;
    checks++; if (groups != 5 || samp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d groups %0d left expected 5 groups 0 left",
                         groups, samp_q.size());
    end
  endtask

  initial begin
    Reset = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; flush1 = 1'b0;
    @(negedge Clock);
    test_reset;
    test_full_group;
    test_flush_partial;
    test_flush_empty;
    test_flush_concurrent;
    test_reset_in_hold;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
